// File: rtl/prog_loader.sv
// UART-fed program loader: parses SYNC, 16-bit big-endian word count, then 3 bytes per 18-bit word.
// Optional trailing modulo-256 checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [9:0]  address,
  output logic [17:0] instruction,
  output logic [3:0]  WEA,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE = 4'd0, LEN_H = 4'd1, LEN_L = 4'd2, B0 = 4'd3, B1 = 4'd4,
    B2 = 4'd5, CSUM = 4'd6, DONE = 4'd7, ERR = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE = 4'd0, LEN_H = 4'd1, LEN_L = 4'd2, B0 = 4'd3, B1 = 4'd4,
    B2 = 4'd5, DONE = 4'd7, ERR = 4'd8
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [9:0]    last_q, last_d;
  logic [1:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [9:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [9:0]    addr_q, addr_d;
  logic [17:0]   instr_q, instr_d;
  logic [3:0]    wea_q, wea_d;
  logic          cpu_q, cpu_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  logic [15:0]   len_s;
  logic          frame_s;

  assign len_s   = {len_hi_q, rx_data};
  assign frame_s = !(state_q inside {IDLE, DONE, ERR});

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    last_d   = last_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    wea_d    = 4'b0000;
    cpu_d    = cpu_q;
    done_d   = done_q;
    err_d    = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (!frame_s) begin
      tcnt_d = '0;
      if (rx_valid && (rx_data == SYNC_BYTE)) begin
        state_d = LEN_H;
        cpu_d   = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wcnt_d  = 10'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = 8'd0;
`endif
      end else begin
        state_d = state_q;
      end
    end else if (rx_valid) begin
      // A byte landing on the expiry cycle wins over the timeout
      tcnt_d = '0;
      case (state_q)
        LEN_H: begin
          len_hi_d = rx_data;
          state_d  = LEN_L;
        end
        LEN_L: begin
          if ((len_s == 16'd0) || (len_s > 16'd1024)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            last_d  = 10'(len_s - 16'd1);
            state_d = B0;
          end
        end
        B0: begin
          b0_d    = rx_data[1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q + rx_data;
`endif
          state_d = B1;
        end
        B1: begin
          b1_d    = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q + rx_data;
`endif
          state_d = B2;
        end
        B2: begin
          wea_d   = 4'b0011;
          addr_d  = wcnt_q;
          instr_d = {b0_q, b1_q, rx_data};
          wcnt_d  = wcnt_q + 10'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q + rx_data;
          if (wcnt_q == last_q) begin
            state_d = CSUM;
          end else begin
            state_d = B0;
          end
`else
          if (wcnt_q == last_q) begin
            state_d = DONE;
            cpu_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = B0;
          end
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM: begin
          if (rx_data == csum_q) begin
            state_d = DONE;
            cpu_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (tcnt_q == T_LAST) begin
      tcnt_d  = '0;
      state_d = ERR;
      err_d   = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_hi_q <= 8'd0;
      last_q   <= 10'd0;
      b0_q     <= 2'd0;
      b1_q     <= 8'd0;
      wcnt_q   <= 10'd0;
      tcnt_q   <= '0;
      addr_q   <= 10'd0;
      instr_q  <= 18'd0;
      wea_q    <= 4'b0000;
      cpu_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      last_q   <= last_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      wea_q    <= wea_d;
      cpu_q    <= cpu_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign address     = addr_q;
  assign instruction = instr_q;
  assign WEA         = wea_q;
  assign cpu_reset   = cpu_q;
  assign load_done   = done_q;
  assign load_error  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: frame-level byte-index model compared every cycle.
module tb_prog_loader;
  localparam int         TO   = 16;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [9:0]  address;
  logic [17:0] instruction;
  logic [3:0]  WEA;
  logic        cpu_reset, load_done, load_error;

  prog_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .address(address), .instruction(instruction), .WEA(WEA),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position inside the current frame is just a byte index
  bit          m_active = 1'b0;
  int          m_k = 0, m_n = 0, m_idle = 0;
  logic [7:0]  m_hi = 8'h00, m_sum = 8'h00;
  logic [7:0]  m_byte [3];
  logic [3:0]  e_wea = 4'b0000;
  logic [9:0]  e_addr = 10'd0;
  logic [17:0] e_instr = 18'd0;
  logic        e_cpu = 1'b0, e_done = 1'b0, e_err = 1'b0;
  bit          e_chk_ai = 1'b0;

  int          dut_writes = 0;
  logic [17:0] dut_mem [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int pos, wi;
    e_wea    = 4'b0000;
    e_chk_ai = 1'b0;
    if (!reset_n) begin
      m_active = 1'b0;
      e_addr = 10'd0; e_instr = 18'd0;
      e_cpu = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_chk_ai = 1'b1;
    end else if (m_active) begin
      if (rx_valid) begin
        m_idle = 0;
        if (m_k == 0) begin
          m_hi = rx_data;
        end else if (m_k == 1) begin
          m_n = int'({m_hi, rx_data});
          if (m_n == 0 || m_n > 1024) begin
            m_active = 1'b0; e_err = 1'b1;
          end
        end else if (m_k < 2 + 3 * m_n) begin
          pos = (m_k - 2) % 3;
          wi  = (m_k - 2) / 3;
          m_byte[pos] = rx_data;
          m_sum = m_sum + rx_data;
          if (pos == 2) begin
            e_wea    = 4'b0011;
            e_addr   = wi[9:0];
            e_instr  = {m_byte[0][1:0], m_byte[1], m_byte[2]};
            e_chk_ai = 1'b1;
            if (wi == m_n - 1 && !CSUM_ON) begin
              m_active = 1'b0; e_cpu = 1'b0; e_done = 1'b1;
            end
          end
        end else begin
          m_active = 1'b0;
          if (rx_data == m_sum) begin
            e_cpu = 1'b0; e_done = 1'b1;
          end else begin
            e_err = 1'b1;
          end
        end
        m_k++;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_active = 1'b0; e_err = 1'b1;
        end
      end
    end else if (rx_valid && rx_data == SYNC) begin
      m_active = 1'b1; m_k = 0; m_idle = 0; m_sum = 8'h00;
      e_cpu = 1'b1; e_done = 1'b0; e_err = 1'b0;
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    check("wea", 32'(WEA), 32'(e_wea));
    check("cpu_reset", 32'(cpu_reset), 32'(e_cpu));
    check("load_done", 32'(load_done), 32'(e_done));
    check("load_error", 32'(load_error), 32'(e_err));
    if (e_chk_ai) begin
      check("address", 32'(address), 32'(e_addr));
      check("instruction", 32'(instruction), 32'(e_instr));
    end
    if (WEA == 4'b0011) begin
      dut_mem[address] = instruction;
      dut_writes++;
    end
  end

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] payload_sum(input logic [7:0] q[$]);
    logic [7:0] s = 8'h00;
    for (int i = 3; i < q.size(); i++) s = s + q[i];
    return s;
  endfunction

  // Sends a frame (sync onward); appends checksum when enabled, corrupted if bad
  task automatic send_frame(input logic [7:0] q[$], input int maxgap, input bit bad);
    logic [7:0] s;
    for (int i = 0; i < q.size(); i++) send(q[i], $urandom_range(0, maxgap));
    s = payload_sum(q);
    if (CSUM_ON) send(bad ? s + 8'h01 : s, $urandom_range(0, maxgap));
  endtask

  function automatic void push_word(inout logic [7:0] q[$], input logic [17:0] w);
    logic [7:0] r = 8'($urandom);
    q.push_back({r[7:2], w[17:16]});
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
  endfunction

  initial begin
    logic [7:0]  q[$];
    logic [17:0] w;
    logic [15:0] n16;
    int          n;
    logic [7:0]  g;

    // Reset state
    idle(2);
    check("rst_wea", 32'(WEA), 32'h0);
    check("rst_addr", 32'(address), 32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_flags", 32'({cpu_reset, load_done, load_error}), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // Single word; upper bits of the first data byte are ignored
    dut_writes = 0;
    q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34};
    check("model_csum_a", 32'(payload_sum(q)), 32'h46);
    send_frame(q, 0, 1'b0);
    idle(2);
    check("a_writes", 32'(dut_writes), 32'd1);
    check("a_mem0", 32'(dut_mem[0]), 32'h01234);
    check("a_done", 32'({load_done, load_error, cpu_reset}), 32'b100);

    // Two words with a SYNC value carried as data
    dut_writes = 0;
    q = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h01, 8'hA5, 8'h5A};
    check("model_csum_b", 32'(payload_sum(q)), 32'h01);
    send_frame(q, 2, 1'b0);
    idle(2);
    check("b_writes", 32'(dut_writes), 32'd2);
    check("b_mem0", 32'(dut_mem[0]), 32'h3FFFF);
    check("b_mem1", 32'(dut_mem[1]), 32'h1A55A);
    check("b_done", 32'({load_done, load_error, cpu_reset}), 32'b100);

    // Illegal lengths
    dut_writes = 0;
    send(8'hA5, 0); send(8'h00, 1); send(8'h00, 0);
    idle(2);
    check("len0_flags", 32'({load_done, load_error, cpu_reset}), 32'b011);
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    idle(2);
    check("len1025_flags", 32'({load_done, load_error, cpu_reset}), 32'b011);
    check("badlen_writes", 32'(dut_writes), 32'd0);

    // Wrong checksum: word still written, frame rejected
    if (CSUM_ON) begin
      dut_writes = 0;
      q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h00};
      for (int i = 0; i < q.size(); i++) send(q[i], 0);
      idle(2);
      check("csum_writes", 32'(dut_writes), 32'd1);
      check("csum_flags", 32'({load_done, load_error}), 32'b01);
    end

    // Timeout after the second data byte, then a byte exactly on the expiry cycle
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h12, 0);
    idle(TO + 1);
    check("to_flags", 32'({load_done, load_error, cpu_reset}), 32'b011);
    dut_writes = 0;
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h12, 0);
    send(8'h34, TO - 1);
    if (CSUM_ON) send(8'h46, TO - 1);
    idle(2);
    check("edge_writes", 32'(dut_writes), 32'd1);
    check("edge_flags", 32'({load_done, load_error, cpu_reset}), 32'b100);

    // Reset pulse in the middle of word 3 of an 8-word frame
    dut_writes = 0;
    q = '{8'hA5, 8'h00, 8'h08};
    for (int i = 0; i < 3; i++) push_word(q, 18'(i + 1));
    for (int i = 0; i < q.size(); i++) send(q[i], 0);
    send(8'h01, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_flags", 32'({cpu_reset, load_done, load_error}), 32'h0);
    check("rst_mid_ai", 32'({address, instruction}), 32'h0);
    send(8'h12, 0); send(8'h34, 0);
    idle(5);
    check("rst_mid_writes", 32'(dut_writes), 32'd3);
    q = '{8'hA5, 8'h00, 8'h01};
    push_word(q, 18'h2BEEF);
    send_frame(q, 1, 1'b0);
    idle(2);
    check("after_rst_mem0", 32'(dut_mem[0]), 32'h2BEEF);
    check("after_rst_done", 32'(load_done), 32'd1);

    // Largest legal frame
    dut_writes = 0;
    q = '{8'hA5, 8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) push_word(q, 18'h2AAAA ^ 18'(i));
    send_frame(q, 0, 1'b0);
    idle(2);
    check("max_writes", 32'(dut_writes), 32'd1024);
    check("max_mem0", 32'(dut_mem[0]), 32'h2AAAA);
    check("max_mem1023", 32'(dut_mem[1023]), 32'h2A955);
    check("max_done", 32'(load_done), 32'd1);

    // Random frames with noise, bad checksums and abandoned frames
    for (int t = 0; t < 40; t++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send(g, $urandom_range(0, 3));
      end
      n   = $urandom_range(1, 6);
      n16 = 16'(n);
      q   = '{SYNC, n16[15:8], n16[7:0]};
      for (int i = 0; i < n; i++) begin
        w = 18'($urandom);
        push_word(q, w);
      end
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 4; i++) send(q[i], 0);
        idle(TO + 2);
      end else begin
        send_frame(q, 3, ($urandom_range(0, 3) == 0));
        idle($urandom_range(0, 4));
      end
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
